// File: rtl/mem_req_arbiter_pkg.sv
// Shared request/response message types for the memory request arbiter.
package mem_req_arbiter_pkg;

  localparam int unsigned MemOpaqBits = 8;

  localparam logic MEM_OP_READ  = 1'b0;
  localparam logic MEM_OP_WRITE = 1'b1;

  typedef logic [MemOpaqBits-1:0] mem_opaq_t;

  typedef struct packed {
    logic        op;
    mem_opaq_t   opaque;
    logic [31:0] addr;
    logic [31:0] data;
  } mem_req_t;

  typedef struct packed {
    logic        op;
    mem_opaq_t   opaque;
    logic [31:0] data;
  } mem_resp_t;

endpackage

// File: rtl/arb_id_fifo.sv
// In-flight requester ID FIFO; memory answers in order, so the head owns the next response.
module arb_id_fifo #(
  parameter int unsigned p_width = 1,
  parameter int unsigned p_depth = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [p_width-1:0]       push_data,
  input  logic                     pop,
  output logic                     full,
  output logic                     empty,
  output logic [p_width-1:0]       head,
  output logic [$clog2(p_depth):0] count
);

  localparam int unsigned PtrW = $clog2(p_depth);

  logic [p_width-1:0] mem_q [p_depth];
  logic [PtrW-1:0]    wr_ptr_q;
  logic [PtrW-1:0]    rd_ptr_q;
  logic [PtrW:0]      count_q;
  logic               do_push;
  logic               do_pop;

  assign full    = (count_q == (PtrW + 1)'(p_depth));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem_q[rd_ptr_q];
  assign count   = count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      if (do_push && !do_pop) begin
        count_q <= count_q + (PtrW + 1)'(1);
      end else if (do_pop && !do_push) begin
        count_q <= count_q - (PtrW + 1)'(1);
      end
    end
  end

  // Storage needs no reset: entries are only read while counted as valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/mem_req_arbiter.sv
// Round-robin arbiter sharing one in-order memory port among several requesters.
module mem_req_arbiter
  import mem_req_arbiter_pkg::*;
#(
  parameter int unsigned p_num_req      = 2,
  parameter int unsigned p_opaq_bits    = 8,
  parameter int unsigned p_max_inflight = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic     [p_num_req-1:0]          req_val,
  output logic     [p_num_req-1:0]          req_rdy,
  input  mem_req_t [p_num_req-1:0]          req_msg,
  output logic     [p_num_req-1:0]          resp_val,
  input  logic     [p_num_req-1:0]          resp_rdy,
  output mem_resp_t                         resp_msg,
  output logic                              mem_req_val,
  input  logic                              mem_req_rdy,
  output mem_req_t                          mem_req_msg,
  input  logic                              mem_resp_val,
  output logic                              mem_resp_rdy,
  input  mem_resp_t                         mem_resp_msg,
  output logic [$clog2(p_max_inflight):0]   inflight,
  output logic                              spurious_err
);

  localparam int unsigned IdW = (p_num_req > 1) ? $clog2(p_num_req) : 1;

  if (p_opaq_bits != MemOpaqBits) begin : g_bad_opaq
    $error("p_opaq_bits must match the package opaque width");
  end
  if (p_num_req < 2 || p_num_req > 8) begin : g_bad_num_req
    $error("p_num_req must be in 2..8");
  end

  logic [IdW-1:0] ptr_q, ptr_d;
  logic [IdW-1:0] grant;
  logic [IdW:0]   idx;
  logic [IdW:0]   nxt;
  logic           found;
  logic           any_req;
  logic           req_fire;
  logic           resp_fire;
  logic           fifo_full;
  logic           fifo_empty;
  logic [IdW-1:0] fifo_head;
  logic           spurious_q;

  // First valid requester at or after ptr, wrapping mod p_num_req.
  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < int'(p_num_req); k++) begin
      idx = {1'b0, ptr_q} + (IdW + 1)'(k);
      if (idx >= (IdW + 1)'(p_num_req)) idx = idx - (IdW + 1)'(p_num_req);
      if (!found && req_val[idx[IdW-1:0]]) begin
        found = 1'b1;
        grant = idx[IdW-1:0];
      end
    end
  end

  assign any_req     = |req_val;
  // Gated by rst so nothing looks ready while reset is held.
  assign mem_req_val = any_req && !fifo_full && !rst;
  assign mem_req_msg = req_msg[grant];
  assign req_fire    = mem_req_val && mem_req_rdy;

  always_comb begin
    req_rdy = '0;
    if (req_fire) req_rdy[grant] = 1'b1;
  end

  always_comb begin
    nxt   = {1'b0, grant} + (IdW + 1)'(1);
    ptr_d = ptr_q;
    if (req_fire) begin
      ptr_d = (nxt == (IdW + 1)'(p_num_req)) ? '0 : nxt[IdW-1:0];
    end
  end

  always_comb begin
    resp_val = '0;
    if (mem_resp_val && !fifo_empty) resp_val[fifo_head] = 1'b1;
  end

  assign mem_resp_rdy = !fifo_empty && resp_rdy[fifo_head];
  assign resp_fire    = mem_resp_val && mem_resp_rdy;
  assign resp_msg     = mem_resp_msg;
  assign spurious_err = spurious_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q      <= '0;
      spurious_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
      if (mem_resp_val && fifo_empty) spurious_q <= 1'b1;
    end
  end

  arb_id_fifo #(
    .p_width (IdW),
    .p_depth (p_max_inflight)
  ) u_id_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (req_fire),
    .push_data (grant),
    .pop       (resp_fire),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (fifo_head),
    .count     (inflight)
  );

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Bench for mem_req_arbiter: queue-based reference model plus directed literal scenarios.
module tb_mem_req_arbiter;
  import mem_req_arbiter_pkg::*;

  localparam int NREQ = 2;
  localparam int MAXI = 4;
  localparam int IW   = $clog2(NREQ);
  localparam int CW   = $clog2(MAXI) + 1;

  logic                   clk = 1'b0;
  logic                   rst;
  logic     [NREQ-1:0]    req_val;
  logic     [NREQ-1:0]    req_rdy;
  mem_req_t [NREQ-1:0]    req_msg;
  logic     [NREQ-1:0]    resp_val;
  logic     [NREQ-1:0]    resp_rdy;
  mem_resp_t              resp_msg;
  logic                   mem_req_val;
  logic                   mem_req_rdy;
  mem_req_t               mem_req_msg;
  logic                   mem_resp_val;
  logic                   mem_resp_rdy;
  mem_resp_t              mem_resp_msg;
  logic [CW-1:0]          inflight;
  logic                   spurious_err;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: ordered owners of outstanding requests.
  logic [IW-1:0] m_q[$];
  int            m_ptr = 0;
  logic          m_err = 1'b0;

  mem_req_arbiter #(
    .p_num_req      (NREQ),
    .p_opaq_bits    (8),
    .p_max_inflight (MAXI)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_val      (req_val),
    .req_rdy      (req_rdy),
    .req_msg      (req_msg),
    .resp_val     (resp_val),
    .resp_rdy     (resp_rdy),
    .resp_msg     (resp_msg),
    .mem_req_val  (mem_req_val),
    .mem_req_rdy  (mem_req_rdy),
    .mem_req_msg  (mem_req_msg),
    .mem_resp_val (mem_resp_val),
    .mem_resp_rdy (mem_resp_rdy),
    .mem_resp_msg (mem_resp_msg),
    .inflight     (inflight),
    .spurious_err (spurious_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, then advance the model.
  always @(negedge clk) begin
    int            g;
    int            c;
    logic [NREQ-1:0] rv;
    logic [NREQ-1:0] e_rdy;
    logic [NREQ-1:0] e_rv;
    logic          any;
    logic          full;
    logic          empty;
    logic          fire;
    logic          e_mrr;
    logic [IW-1:0] gi;
    if (rst) begin
      m_q.delete();
      m_ptr = 0;
      m_err = 1'b0;
      chk("rst_req_rdy", 128'(req_rdy), 128'(0));
      chk("rst_mem_req_val", 128'(mem_req_val), 128'(0));
      chk("rst_resp_val", 128'(resp_val), 128'(0));
      chk("rst_mem_resp_rdy", 128'(mem_resp_rdy), 128'(0));
      chk("rst_inflight", 128'(inflight), 128'(0));
      chk("rst_spurious", 128'(spurious_err), 128'(0));
    end else begin
      any   = |req_val;
      full  = (m_q.size() == MAXI);
      empty = (m_q.size() == 0);
      g     = -1;
      for (int k = 0; k < NREQ; k++) begin
        c  = (m_ptr + k) % NREQ;
        rv = req_val >> c;
        if (g < 0 && rv[0]) g = c;
      end
      gi    = (g < 0) ? '0 : IW'(g);
      fire  = any && !full && mem_req_rdy;
      e_rdy = '0;
      if (fire) e_rdy[gi] = 1'b1;
      e_rv  = '0;
      e_mrr = 1'b0;
      if (!empty) begin
        if (mem_resp_val) e_rv[m_q[0]] = 1'b1;
        e_mrr = resp_rdy[m_q[0]];
      end
      chk("mem_req_val", 128'(mem_req_val), 128'(any && !full));
      chk("req_rdy", 128'(req_rdy), 128'(e_rdy));
      if (any) chk("mem_req_msg", 128'(mem_req_msg), 128'(req_msg[gi]));
      chk("resp_val", 128'(resp_val), 128'(e_rv));
      chk("mem_resp_rdy", 128'(mem_resp_rdy), 128'(e_mrr));
      chk("resp_msg", 128'(resp_msg), 128'(mem_resp_msg));
      chk("inflight", 128'(inflight), 128'(m_q.size()));
      chk("spurious_err", 128'(spurious_err), 128'(m_err));
      if (mem_resp_val && empty) m_err = 1'b1;
      if (mem_resp_val && e_mrr) void'(m_q.pop_front());
      if (fire) begin
        m_q.push_back(gi);
        m_ptr = (g + 1) % NREQ;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req_val      = '0;
    resp_rdy     = '0;
    mem_req_rdy  = 1'b0;
    mem_resp_val = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      req_msg[i].op     = MEM_OP_READ;
      req_msg[i].opaque = 8'(i);
      req_msg[i].addr   = 32'h1000 + 32'(i);
      req_msg[i].data   = 32'hd000 + 32'(i);
    end
    mem_resp_msg = '0;
  endtask

  task automatic do_reset();
    step();
    rst = 1'b1;
    idle_inputs();
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic randomize_inputs();
    req_val     = NREQ'($urandom);
    resp_rdy    = NREQ'($urandom);
    mem_req_rdy = ($urandom_range(0, 3) != 0);
    for (int i = 0; i < NREQ; i++) begin
      req_msg[i].op     = ($urandom_range(0, 1) != 0) ? MEM_OP_WRITE : MEM_OP_READ;
      req_msg[i].opaque = 8'($urandom);
      req_msg[i].addr   = $urandom;
      req_msg[i].data   = $urandom;
    end
    if (m_q.size() > 0) mem_resp_val = ($urandom_range(0, 9) < 6);
    else mem_resp_val = ($urandom_range(0, 99) < 2);
    mem_resp_msg.op     = 1'($urandom);
    mem_resp_msg.opaque = 8'($urandom);
    mem_resp_msg.data   = $urandom;
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    do_reset();

    // Both valid: grants alternate starting at 0, then responses alternate.
    req_val = 2'b11; mem_req_rdy = 1'b1; resp_rdy = 2'b11;
    #1 chk("t1_grant0", 128'(req_rdy), 128'(2'b01)); step();
    #1 chk("t1_grant1", 128'(req_rdy), 128'(2'b10)); step();
    #1 chk("t1_grant2", 128'(req_rdy), 128'(2'b01)); step();
    #1 chk("t1_grant3", 128'(req_rdy), 128'(2'b10)); step();
    #1 chk("t1_full_val", 128'(mem_req_val), 128'(0));
    chk("t1_inflight4", 128'(inflight), 128'(4));
    req_val = '0; mem_resp_val = 1'b1;
    #1 chk("t1_resp0", 128'(resp_val), 128'(2'b01)); step();
    #1 chk("t1_resp1", 128'(resp_val), 128'(2'b10)); step();
    #1 chk("t1_resp2", 128'(resp_val), 128'(2'b01)); step();
    #1 chk("t1_resp3", 128'(resp_val), 128'(2'b10)); step();
    mem_resp_val = 1'b0;
    #1 chk("t1_drained", 128'(inflight), 128'(0));

    // Only requester 1 for three cycles, then both: 1,1,1,0,1.
    do_reset();
    req_val = 2'b10; mem_req_rdy = 1'b1; resp_rdy = 2'b11;
    #1 chk("t2_g0", 128'(req_rdy), 128'(2'b10)); step();
    mem_resp_val = 1'b1;
    #1 chk("t2_g1", 128'(req_rdy), 128'(2'b10)); step();
    #1 chk("t2_g2", 128'(req_rdy), 128'(2'b10)); step();
    req_val = 2'b11;
    #1 chk("t2_g3", 128'(req_rdy), 128'(2'b01)); step();
    #1 chk("t2_g4", 128'(req_rdy), 128'(2'b10));
    chk("t2_resp_owner", 128'(resp_val), 128'(2'b01)); step();
    req_val = '0; mem_resp_val = 1'b0;
    #1 chk("t2_no_spurious", 128'(spurious_err), 128'(0));

    // Fill to capacity, 5th blocked, pop does not unblock in the same cycle.
    do_reset();
    req_val = 2'b01; mem_req_rdy = 1'b1; resp_rdy = 2'b01;
    repeat (4) step();
    #1 chk("t3_inflight4", 128'(inflight), 128'(4));
    chk("t3_blocked_rdy", 128'(req_rdy), 128'(0));
    chk("t3_blocked_val", 128'(mem_req_val), 128'(0));
    mem_resp_val = 1'b1;
    #1 chk("t3_pop_rdy", 128'(mem_resp_rdy), 128'(1));
    chk("t3_still_blocked", 128'(req_rdy), 128'(0)); step();
    mem_resp_val = 1'b0;
    #1 chk("t3_unblocked", 128'(req_rdy), 128'(2'b01));
    chk("t3_inflight3", 128'(inflight), 128'(3)); step();
    #1 chk("t3_inflight4b", 128'(inflight), 128'(4));
    req_val = '0;

    // Response to requester 1 held off by resp_rdy.
    do_reset();
    req_val = 2'b10; mem_req_rdy = 1'b1; step();
    req_val = '0; mem_resp_val = 1'b1; resp_rdy = 2'b01;
    mem_resp_msg.op = MEM_OP_WRITE; mem_resp_msg.opaque = 8'h5a; mem_resp_msg.data = 32'hcafe_f00d;
    for (int i = 0; i < 3; i++) begin
      #1 chk("t4_hold_rdy", 128'(mem_resp_rdy), 128'(0));
      chk("t4_hold_val", 128'(resp_val), 128'(2'b10));
      chk("t4_hold_msg", 128'(resp_msg), 128'({1'b1, 8'h5a, 32'hcafe_f00d}));
      step();
    end
    resp_rdy = 2'b10;
    #1 chk("t4_release", 128'(mem_resp_rdy), 128'(1)); step();
    mem_resp_val = 1'b0;
    #1 chk("t4_inflight0", 128'(inflight), 128'(0));

    // Spurious response is sticky until reset.
    do_reset();
    mem_resp_val = 1'b1; resp_rdy = 2'b11;
    #1 chk("t5_rdy0", 128'(mem_resp_rdy), 128'(0)); step();
    mem_resp_val = 1'b0;
    #1 chk("t5_set", 128'(spurious_err), 128'(1));
    req_val = 2'b01; mem_req_rdy = 1'b1; step();
    req_val = '0; mem_resp_val = 1'b1; step();
    mem_resp_val = 1'b0;
    #1 chk("t5_sticky", 128'(spurious_err), 128'(1));
    do_reset();
    #1 chk("t5_cleared", 128'(spurious_err), 128'(0));

    // Asynchronous reset mid-stream with three outstanding.
    req_val = 2'b11; mem_req_rdy = 1'b1;
    repeat (3) step();
    #1 chk("t6_inflight3", 128'(inflight), 128'(3));
    rst = 1'b1;
    #1 chk("t6_async_rdy", 128'(req_rdy), 128'(0));
    chk("t6_async_val", 128'(mem_req_val), 128'(0));
    chk("t6_async_cnt", 128'(inflight), 128'(0));
    step();
    rst = 1'b0;
    #1 chk("t6_first_grant", 128'(req_rdy), 128'(2'b01)); step();
    req_val = '0; mem_resp_val = 1'b1; resp_rdy = 2'b11; step();
    mem_resp_val = 1'b1; step();
    mem_resp_val = 1'b0; step();
    #1 chk("t6_late_resp_spurious", 128'(spurious_err), 128'(1));

    // Randomized traffic checked every cycle by the model.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      randomize_inputs();
      if (n == 1500) begin
        step();
        do_reset();
      end
      step();
    end
    idle_inputs();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
